// File: rtl/pipe_skid_chain.sv
// Valid/ready slice chain: bypass, forward-registered or full-skid slices in series,
// with synchronous flush and a registered occupancy count.
module pipe_skid_chain #(
  parameter  int DATA_W = 16,
  parameter  int STAGES = 2,
  parameter  int MODE   = 2,
  localparam int OCC_W  = $clog2(2*STAGES+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy
);

  if (MODE == 0) begin : gBypass
    logic unusedInputs;
    assign unusedInputs = ^{clk, rst_n, flush};

    assign in_rdy    = out_rdy;
    assign out_vld   = in_vld;
    assign out_data  = in_data;
    assign occupancy = '0;

  end else begin : gChain
    logic             inXfer;
    logic             outXfer;
    logic [OCC_W-1:0] occQ;
    logic [OCC_W-1:0] occD;

    assign inXfer  = in_vld & in_rdy;
    assign outXfer = out_vld & out_rdy;

    // Tracks held beats from port handshakes rather than summing valid bits.
    always_comb begin
      occD = occQ;
      if (flush) begin
        occD = '0;
      end else if (inXfer && !outXfer) begin
        occD = occQ + OCC_W'(1);
      end else if (outXfer && !inXfer) begin
        occD = occQ - OCC_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        occQ <= '0;
      end else begin
        occQ <= occD;
      end
    end

    assign occupancy = occQ;

    if (MODE == 1) begin : gFwd
      logic [STAGES-1:0] vldQ;
      logic [STAGES-1:0] vldD;
      logic [STAGES-1:0] sRdy;
      logic [STAGES:0]   chainVld;
      logic [DATA_W-1:0] dataQ     [STAGES];
      logic [DATA_W-1:0] dataD     [STAGES];
      logic [DATA_W-1:0] chainData [STAGES+1];

      // Position 0 is the input port, position s+1 is the output of slice s.
      assign chainVld = {vldQ, in_vld};

      always_comb begin
        chainData[0] = in_data;
        for (int s = 0; s < STAGES; s++) begin
          chainData[s+1] = dataQ[s];
        end
      end

      // A slice is ready if it or any slice after it has a hole, or the sink is ready.
      always_comb begin
        sRdy = '0;
        for (int s = 0; s < STAGES; s++) begin
          sRdy[s] = out_rdy;
          for (int t = s; t < STAGES; t++) begin
            if (!vldQ[t]) begin
              sRdy[s] = 1'b1;
            end
          end
        end
      end

      always_comb begin
        vldD  = vldQ;
        dataD = dataQ;
        if (flush) begin
          vldD = '0;
        end else begin
          for (int s = 0; s < STAGES; s++) begin
            if (sRdy[s]) begin
              vldD[s] = chainVld[s];
              if (chainVld[s]) begin
                dataD[s] = chainData[s];
              end
            end
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vldQ <= '0;
          for (int s = 0; s < STAGES; s++) begin
            dataQ[s] <= '0;
          end
        end else begin
          vldQ  <= vldD;
          dataQ <= dataD;
        end
      end

      assign in_rdy   = sRdy[0] & ~flush;
      assign out_vld  = chainVld[STAGES];
      assign out_data = chainData[STAGES];

    end else begin : gSkid
      logic [STAGES-1:0] mVldQ;
      logic [STAGES-1:0] mVldD;
      logic [STAGES-1:0] kVldQ;
      logic [STAGES-1:0] kVldD;
      logic [STAGES:0]   chainVld;
      logic [STAGES:0]   downRdy;
      logic [DATA_W-1:0] mDataQ    [STAGES];
      logic [DATA_W-1:0] mDataD    [STAGES];
      logic [DATA_W-1:0] kDataQ    [STAGES];
      logic [DATA_W-1:0] kDataD    [STAGES];
      logic [DATA_W-1:0] chainData [STAGES+1];
      logic              accept;
      logic              drain;

      // Ready seen at position s is the registered ~skid-valid of slice s; the sink sits last.
      assign chainVld = {mVldQ, in_vld};
      assign downRdy  = {out_rdy, ~kVldQ};

      always_comb begin
        chainData[0] = in_data;
        for (int s = 0; s < STAGES; s++) begin
          chainData[s+1] = mDataQ[s];
        end
      end

      always_comb begin
        mVldD  = mVldQ;
        kVldD  = kVldQ;
        mDataD = mDataQ;
        kDataD = kDataQ;
        accept = 1'b0;
        drain  = 1'b0;
        if (flush) begin
          mVldD = '0;
          kVldD = '0;
        end else begin
          for (int s = 0; s < STAGES; s++) begin
            accept = chainVld[s] & downRdy[s];
            drain  = mVldQ[s] & downRdy[s+1];
            if (drain) begin
              if (kVldQ[s]) begin
                mDataD[s] = kDataQ[s];
                kVldD[s]  = 1'b0;
              end else begin
                mVldD[s] = accept;
                if (accept) begin
                  mDataD[s] = chainData[s];
                end
              end
            end else if (accept) begin
              if (!mVldQ[s]) begin
                mVldD[s]  = 1'b1;
                mDataD[s] = chainData[s];
              end else begin
                kVldD[s]  = 1'b1;
                kDataD[s] = chainData[s];
              end
            end
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mVldQ <= '0;
          kVldQ <= '0;
          for (int s = 0; s < STAGES; s++) begin
            mDataQ[s] <= '0;
            kDataQ[s] <= '0;
          end
        end else begin
          mVldQ  <= mVldD;
          kVldQ  <= kVldD;
          mDataQ <= mDataD;
          kDataQ <= kDataD;
        end
      end

      assign in_rdy   = downRdy[0] & ~flush;
      assign out_vld  = chainVld[STAGES];
      assign out_data = chainData[STAGES];
    end
  end

endmodule

// File: tb/tb_pipe_skid_chain.sv
// Scoreboard bench for pipe_skid_chain: four instances covering skid, forward and bypass
// modes, driven by directed scenarios followed by a long randomised run.
module tb_pipe_skid_chain;

  localparam int N  = 4;
  localparam int DW = 16;

  function automatic int modeOf(input int k);
    case (k)
      0:       return 2;
      1:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int stagesOf(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int capOf(input int k);
    return (modeOf(k) == 2) ? 2 * stagesOf(k) : stagesOf(k);
  endfunction

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          flushS  [N];
  logic          inVld   [N];
  logic          inRdy   [N];
  logic          outVld  [N];
  logic          outRdy  [N];
  logic [DW-1:0] inData  [N];
  logic [DW-1:0] outData [N];
  logic [3:0]    occ     [N];

  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : gDut
    localparam int OW = $clog2(2*stagesOf(k)+1);
    logic [OW-1:0] occW;

    pipe_skid_chain #(
      .DATA_W(DW),
      .STAGES(stagesOf(k)),
      .MODE  (modeOf(k))
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flushS[k]),
      .in_vld   (inVld[k]),
      .in_rdy   (inRdy[k]),
      .in_data  (inData[k]),
      .out_vld  (outVld[k]),
      .out_rdy  (outRdy[k]),
      .out_data (outData[k]),
      .occupancy(occW)
    );

    assign occ[k] = 4'(occW);
  end

  logic [DW-1:0] sbQ [N][$];
  logic [DW-1:0] nextData [N];
  logic [DW-1:0] prevData [N];
  logic          prevStall [N];
  int            accepted [N];
  int            received [N];
  int            maxOcc   [N];
  int            checks   = 0;
  int            failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Per-cycle scoreboard step for one instance, run after inputs have settled.
  task automatic scoreCycle(input int i);
    logic inX;
    logic outX;
    logic [DW-1:0] exp;
    inX  = inVld[i] & inRdy[i];
    outX = outVld[i] & outRdy[i];
    if (modeOf(i) == 0) begin
      checkOutput($sformatf("byp_rdy%0d", i), 32'(inRdy[i]), 32'(outRdy[i]));
      checkOutput($sformatf("byp_vld%0d", i), 32'(outVld[i]), 32'(inVld[i]));
      checkOutput($sformatf("byp_data%0d", i), 32'(outData[i]), 32'(inData[i]));
      checkOutput($sformatf("byp_occ%0d", i), 32'(occ[i]), 32'd0);
    end else begin
      checkOutput($sformatf("occ%0d", i), 32'(occ[i]), 32'(sbQ[i].size()));
      checkOutput($sformatf("cap%0d", i), 32'(sbQ[i].size() <= capOf(i)), 32'd1);
      if (flushS[i]) checkOutput($sformatf("flushRdy%0d", i), 32'(inRdy[i]), 32'd0);
      if (prevStall[i]) begin
        checkOutput($sformatf("stallVld%0d", i), 32'(outVld[i]), 32'd1);
        checkOutput($sformatf("stallData%0d", i), 32'(outData[i]), 32'(prevData[i]));
      end
      if (32'(occ[i]) > maxOcc[i]) maxOcc[i] = 32'(occ[i]);
    end
    if (inX) begin
      sbQ[i].push_back(inData[i]);
      nextData[i] = nextData[i] + 1'b1;
      accepted[i]++;
    end
    if (outX) begin
      checkOutput($sformatf("nonEmpty%0d", i), 32'(sbQ[i].size() != 0), 32'd1);
      if (sbQ[i].size() != 0) begin
        exp = sbQ[i].pop_front();
        checkOutput($sformatf("data%0d", i), 32'(outData[i]), 32'(exp));
      end
      received[i]++;
    end
    prevStall[i] = outVld[i] & ~outRdy[i] & ~flushS[i];
    prevData[i]  = outData[i];
    if (flushS[i] && modeOf(i) != 0) sbQ[i].delete();
  endtask

  // Called at the falling edge with inputs already driven; returns at the next falling edge.
  task automatic applyStimulus();
    #1;
    for (int i = 0; i < N; i++) scoreCycle(i);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleAll();
    for (int i = 0; i < N; i++) begin
      inVld[i]  = 1'b0;
      flushS[i] = 1'b0;
      outRdy[i] = 1'b0;
      inData[i] = nextData[i];
    end
  endtask

  int doneCycle;
  int acc0;

  initial begin
    for (int i = 0; i < N; i++) begin
      nextData[i]  = 16'h0100 * 16'(i + 1);
      prevData[i]  = '0;
      prevStall[i] = 1'b0;
      accepted[i]  = 0;
      received[i]  = 0;
      maxOcc[i]    = 0;
    end
    idleAll();
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      if (modeOf(i) != 0) begin
        checkOutput($sformatf("rstVld%0d", i), 32'(outVld[i]), 32'd0);
        checkOutput($sformatf("rstData%0d", i), 32'(outData[i]), 32'd0);
        checkOutput($sformatf("rstOcc%0d", i), 32'(occ[i]), 32'd0);
        checkOutput($sformatf("rstRdy%0d", i), 32'(inRdy[i]), 32'd1);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Skid, two stages: eight back-to-back beats with a ready sink.
    nextData[0] = 16'h0001;
    outRdy[0]   = 1'b1;
    doneCycle   = -1;
    for (int c = 0; c < 12; c++) begin
      inVld[0]  = (nextData[0] <= 16'h0008);
      inData[0] = nextData[0];
      #1;
      if (c == 0) checkOutput("t1_rdy", 32'(inRdy[0]), 32'd1);
      if (c == 1) checkOutput("t1_latVld", 32'(outVld[0]), 32'd0);
      if (c == 2) begin
        checkOutput("t1_firstVld", 32'(outVld[0]), 32'd1);
        checkOutput("t1_firstData", 32'(outData[0]), 32'h0001);
      end
      applyStimulus();
      if (received[0] == 8 && doneCycle < 0) doneCycle = c;
    end
    checkOutput("t1_count", 32'(received[0]), 32'd8);
    checkOutput("t1_lastCycle", 32'(doneCycle), 32'd9);
    idleAll();

    // Skid, one stage: sink stalls for three cycles mid-stream.
    nextData[1] = 16'hA000;
    maxOcc[1]   = 0;
    for (int c = 0; c < 14; c++) begin
      inVld[1]  = 1'b1;
      inData[1] = nextData[1];
      outRdy[1] = !(c >= 3 && c <= 5);
      #1;
      if (c == 3) checkOutput("t2_rdyBefore", 32'(inRdy[1]), 32'd1);
      if (c == 4) checkOutput("t2_rdyDrop", 32'(inRdy[1]), 32'd0);
      applyStimulus();
    end
    inVld[1]  = 1'b0;
    outRdy[1] = 1'b1;
    for (int c = 0; c < 10 && sbQ[1].size() != 0; c++) applyStimulus();
    checkOutput("t2_peakOcc", 32'(maxOcc[1]), 32'd2);
    checkOutput("t2_noLoss", 32'(received[1]), 32'(accepted[1]));
    idleAll();

    // Forward-registered, three stages: sink held off until the chain fills.
    nextData[2] = 16'h3000;
    acc0        = accepted[2];
    for (int c = 0; c < 6; c++) begin
      inVld[2]  = 1'b1;
      inData[2] = nextData[2];
      outRdy[2] = 1'b0;
      applyStimulus();
    end
    inData[2] = nextData[2];
    #1;
    checkOutput("t3_accepts", 32'(accepted[2] - acc0), 32'd3);
    checkOutput("t3_rdy", 32'(inRdy[2]), 32'd0);
    checkOutput("t3_occ", 32'(occ[2]), 32'd3);
    checkOutput("t3_vld", 32'(outVld[2]), 32'd1);
    checkOutput("t3_data", 32'(outData[2]), 32'h3000);

    // Flush the full chain while the head beat leaves.
    flushS[2] = 1'b1;
    outRdy[2] = 1'b1;
    #1;
    checkOutput("t4_rdy", 32'(inRdy[2]), 32'd0);
    checkOutput("t4_headVld", 32'(outVld[2]), 32'd1);
    applyStimulus();
    flushS[2] = 1'b0;
    inVld[2]  = 1'b0;
    #1;
    checkOutput("t4_vld", 32'(outVld[2]), 32'd0);
    checkOutput("t4_occ", 32'(occ[2]), 32'd0);
    applyStimulus();
    idleAll();

    // Randomised traffic on all instances, with occasional flushes and one async reset.
    for (int c = 0; c < 10000; c++) begin
      if (c == 5000) begin
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
          if (modeOf(i) != 0) begin
            checkOutput($sformatf("midRstVld%0d", i), 32'(outVld[i]), 32'd0);
            checkOutput($sformatf("midRstData%0d", i), 32'(outData[i]), 32'd0);
            checkOutput($sformatf("midRstOcc%0d", i), 32'(occ[i]), 32'd0);
          end
          sbQ[i].delete();
          prevStall[i] = 1'b0;
        end
        idleAll();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        inVld[i]  = ($urandom_range(99) < ((c < 2500) ? 80 : 50));
        outRdy[i] = ($urandom_range(99) < ((c % 3000) < 1500 ? 40 : 85));
        flushS[i] = ($urandom_range(199) == 0);
        inData[i] = nextData[i];
      end
      applyStimulus();
    end

    idleAll();
    for (int i = 0; i < N; i++) outRdy[i] = 1'b1;
    for (int c = 0; c < 20; c++) applyStimulus();
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("drainEmpty%0d", i), 32'(sbQ[i].size()), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
